// File: rtl/calculator_alu.sv
// ALU responder for the calculator core: ADD/SUB in one cycle,
// MUL (shift-add) and DIV (restoring) one bit per clock.
module calculator_alu #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] i_alu_input_a,
    input  logic [DATA_WIDTH-1:0] i_alu_input_b,
    input  logic [1:0]            i_alu_input_op,
    input  logic                  i_alu_input_signed,
    input  logic                  i_alu_input_valid,
    output logic                  o_alu_input_ready,
    output logic [DATA_WIDTH-1:0] o_alu_result,
    output logic                  o_alu_error,
    output logic                  o_alu_result_valid,
    input  logic                  i_alu_result_ready
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    localparam logic [W-1:0] LIM_POS = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] LIM_NEG = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_COMPUTE,
        S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_next_state;

    logic [1:0]      r_op;
    logic            r_signed;
    logic            r_neg;
    logic [W-1:0]    r_mag_a;
    logic [W-1:0]    r_mag_b;
    logic [2*W-1:0]  r_acc;
    logic [CW-1:0]   r_cnt;
    logic [W-1:0]    r_result;
    logic            r_error;

    logic            w_accept;
    logic            w_consume;
    logic            w_last;

    // single-cycle ADD/SUB path, evaluated straight from the inputs
    logic [W:0]      w_add_full;
    logic [W-1:0]    w_sub;
    logic            w_add_err;
    logic            w_sub_err;
    logic [W-1:0]    w_as_res;
    logic            w_as_err;

    logic [W-1:0]    w_mag_a;
    logic [W-1:0]    w_mag_b;

    // iterative path
    logic [W:0]      w_mul_sum;
    logic [2*W-1:0]  w_mul_next;
    logic [W:0]      w_div_shift;
    logic            w_div_ge;
    logic [W-1:0]    w_div_diff;
    logic [W-1:0]    w_div_rem;
    logic [2*W-1:0]  w_div_next;
    logic [2*W-1:0]  w_iter_next;

    logic [W-1:0]    w_mag_lo;
    logic            w_hi_nz;
    logic            w_ovf;
    logic            w_div0;
    logic [W-1:0]    w_fin_val;
    logic            w_fin_err;
    logic [W-1:0]    w_fin_res;

    assign w_accept  = i_alu_input_valid && (r_state == S_IDLE);
    assign w_consume = i_alu_result_ready && (r_state == S_DONE);
    assign w_last    = (r_cnt == CW'(W - 1));

    assign w_add_full = {1'b0, i_alu_input_a} + {1'b0, i_alu_input_b};
    assign w_sub      = i_alu_input_a - i_alu_input_b;

    assign w_add_err = i_alu_input_signed
        ? ((i_alu_input_a[W-1] == i_alu_input_b[W-1]) &&
           (w_add_full[W-1] != i_alu_input_a[W-1]))
        : w_add_full[W];

    assign w_sub_err = i_alu_input_signed
        ? ((i_alu_input_a[W-1] != i_alu_input_b[W-1]) &&
           (w_sub[W-1] != i_alu_input_a[W-1]))
        : (i_alu_input_b > i_alu_input_a);

    assign w_as_err = (i_alu_input_op == OP_SUB) ? w_sub_err : w_add_err;
    assign w_as_res = w_as_err ? '0
        : ((i_alu_input_op == OP_SUB) ? w_sub : w_add_full[W-1:0]);

    // |-2^(W-1)| wraps to 2^(W-1), which is exactly right when read unsigned
    assign w_mag_a = (i_alu_input_signed && i_alu_input_a[W-1])
        ? (-i_alu_input_a) : i_alu_input_a;
    assign w_mag_b = (i_alu_input_signed && i_alu_input_b[W-1])
        ? (-i_alu_input_b) : i_alu_input_b;

    // MUL: upper half accumulates, lower half shifts the multiplier out
    assign w_mul_sum  = {1'b0, r_acc[2*W-1:W]} +
                        {1'b0, (r_acc[0] ? r_mag_a : {W{1'b0}})};
    assign w_mul_next = {w_mul_sum, r_acc[W-1:1]};

    // DIV: upper half is the remainder, lower half dividend -> quotient
    assign w_div_shift = {r_acc[2*W-1:W], r_acc[W-1]};
    assign w_div_ge    = (w_div_shift >= {1'b0, r_mag_b});
    assign w_div_diff  = w_div_shift[W-1:0] - r_mag_b;
    assign w_div_rem   = w_div_ge ? w_div_diff : w_div_shift[W-1:0];
    assign w_div_next  = {w_div_rem, r_acc[W-2:0], w_div_ge};

    assign w_iter_next = (r_op == OP_MUL) ? w_mul_next : w_div_next;

    // sign fix-up and range check on the final iteration
    assign w_mag_lo = w_iter_next[W-1:0];
    assign w_hi_nz  = (r_op == OP_MUL) && (|w_iter_next[2*W-1:W]);
    assign w_div0   = (r_op == OP_DIV) && (r_mag_b == '0);

    assign w_ovf = w_hi_nz || (r_signed &&
        (r_neg ? (w_mag_lo > LIM_NEG) : (w_mag_lo > LIM_POS)));

    assign w_fin_val = (r_signed && r_neg) ? (-w_mag_lo) : w_mag_lo;
    assign w_fin_err = w_ovf || w_div0;
    assign w_fin_res = w_fin_err ? '0 : w_fin_val;

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // next-state logic
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (i_alu_input_op[1]) begin
                        w_next_state = S_COMPUTE;
                    end else begin
                        w_next_state = S_DONE;
                    end
                end
            end
            S_COMPUTE: begin
                if (w_last) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                if (w_consume) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // operand capture, iteration and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op     <= OP_ADD;
            r_signed <= 1'b0;
            r_neg    <= 1'b0;
            r_mag_a  <= '0;
            r_mag_b  <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_error  <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op     <= i_alu_input_op;
                        r_signed <= i_alu_input_signed;
                        r_cnt    <= '0;
                        if (i_alu_input_op[1]) begin
                            r_mag_a <= w_mag_a;
                            r_mag_b <= w_mag_b;
                            r_neg   <= i_alu_input_signed &&
                                       (i_alu_input_a[W-1] ^ i_alu_input_b[W-1]);
                            r_acc   <= (i_alu_input_op == OP_DIV)
                                ? {{W{1'b0}}, w_mag_a}
                                : {{W{1'b0}}, w_mag_b};
                        end else begin
                            r_result <= w_as_res;
                            r_error  <= w_as_err;
                        end
                    end
                end
                S_COMPUTE: begin
                    r_acc <= w_iter_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_result <= w_fin_res;
                        r_error  <= w_fin_err;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_alu_input_ready  = (r_state == S_IDLE);
    assign o_alu_result_valid = (r_state == S_DONE);
    assign o_alu_result       = r_result;
    assign o_alu_error        = r_error;

endmodule
